// File: rtl/mult_booth_encoder_pkg.sv
// Shared constants, state/digit enums and the Booth triplet decoder for the
// radix-4 multiplier front end.
package mult_booth_encoder_pkg;

    localparam int LENGTH     = 32;
    localparam int NUM_PP     = LENGTH / 2;
    localparam int PP_W       = LENGTH + 1;
    localparam int PP_PER_CYC = 4;
    localparam int NUM_GRP    = NUM_PP / PP_PER_CYC;
    localparam int CNT_W      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int SLOT_W     = (PP_PER_CYC > 1) ? $clog2(PP_PER_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        DONE
    } mult_state_e;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M1,
        M2
    } booth_digit_e;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_e booth_decode(input logic [2:0] trip);
        booth_digit_e digit;
        digit = ZERO;
        case (trip)
            3'b001, 3'b010: digit = P1;
            3'b011:         digit = P2;
            3'b100:         digit = M2;
            3'b101, 3'b110: digit = M1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/mult_booth_encoder_if.sv
// Issuer/adder-facing bundle of the Booth encoder: request side in,
// registered partial bank and status out.
interface mult_booth_encoder_if;
    import mult_booth_encoder_pkg::*;

    logic              start;
    logic              flush;
    logic [LENGTH-1:0] op_a;
    logic [LENGTH-1:0] op_b;
    logic              operation_i;

    logic [PP_W-1:0]   partial1_booth;
    logic [PP_W-1:0]   partial2_booth;
    logic [PP_W-1:0]   partial3_booth;
    logic [PP_W-1:0]   partial4_booth;
    logic [PP_W-1:0]   partial5_booth;
    logic [PP_W-1:0]   partial6_booth;
    logic [PP_W-1:0]   partial7_booth;
    logic [PP_W-1:0]   partial8_booth;
    logic [PP_W-1:0]   partial9_booth;
    logic [PP_W-1:0]   partial10_booth;
    logic [PP_W-1:0]   partial11_booth;
    logic [PP_W-1:0]   partial12_booth;
    logic [PP_W-1:0]   partial13_booth;
    logic [PP_W-1:0]   partial14_booth;
    logic [PP_W-1:0]   partial15_booth;
    logic [PP_W-1:0]   partial16_booth;

    logic              enable_mult;
    logic              operation;
    logic              mult_finish;
    logic              busy;
    logic              pp_ovf;

    modport master (
        output start, flush, op_a, op_b, operation_i,
        input  partial1_booth, partial2_booth, partial3_booth, partial4_booth,
        input  partial5_booth, partial6_booth, partial7_booth, partial8_booth,
        input  partial9_booth, partial10_booth, partial11_booth, partial12_booth,
        input  partial13_booth, partial14_booth, partial15_booth, partial16_booth,
        input  enable_mult, operation, mult_finish, busy, pp_ovf
    );

    modport slave (
        input  start, flush, op_a, op_b, operation_i,
        output partial1_booth, partial2_booth, partial3_booth, partial4_booth,
        output partial5_booth, partial6_booth, partial7_booth, partial8_booth,
        output partial9_booth, partial10_booth, partial11_booth, partial12_booth,
        output partial13_booth, partial14_booth, partial15_booth, partial16_booth,
        output enable_mult, operation, mult_finish, busy, pp_ovf
    );

endinterface

// File: rtl/mult_booth_encoder_booth_digit_enc.sv
// One radix-4 Booth lane: recodes a multiplier triplet and forms the 33-bit
// signed partial product of the multiplicand, flagging 33-bit overflow.
module booth_digit_enc
    import mult_booth_encoder_pkg::*;
(
    input  logic [2:0]        triplet_i,
    input  logic [LENGTH-1:0] op_a_i,
    output logic [PP_W-1:0]   partial_o,
    output logic              ovf_o
);

    booth_digit_e digit;
    logic [PP_W:0] a_ext;
    logic [PP_W:0] prod;

    // Work in 34 bits so that +/-2 of any 32-bit value is exact before truncation.
    always_comb begin
        digit = booth_decode(triplet_i);
        a_ext = {{2{op_a_i[LENGTH-1]}}, op_a_i};
        prod  = '0;
        case (digit)
            ZERO:    prod = '0;
            P1:      prod = a_ext;
            P2:      prod = a_ext << 1;
            M1:      prod = -a_ext;
            M2:      prod = (-a_ext) << 1;
            default: prod = '0;
        endcase
        partial_o = prod[PP_W-1:0];
        ovf_o     = prod[PP_W] ^ prod[PP_W-1];
    end

endmodule

// File: rtl/mult_booth_encoder.sv
// Latches a multiply request, builds the 16 Booth partial products four per
// cycle into a register bank, then flags the bank valid for one cycle.
module mult_booth_encoder
    import mult_booth_encoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    mult_booth_encoder_if.slave  bus
);

    mult_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LENGTH-1:0] op_a_q, op_a_d;
    logic [LENGTH-1:0] op_b_q, op_b_d;
    logic              oper_q, oper_d;
    logic              pp_ovf_q, pp_ovf_d;
    logic [PP_W-1:0]   bank_q [NUM_PP];
    logic [PP_W-1:0]   bank_d [NUM_PP];

    logic [LENGTH:0]   b_ext;
    logic [2:0]        trip_all [NUM_PP];
    logic [PP_W-1:0]   enc_pp   [PP_PER_CYC];
    logic [PP_PER_CYC-1:0] enc_ovf;

    assign b_ext = {op_b_q, 1'b0};

    for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_trip
        assign trip_all[gi] = b_ext[2*gi +: 3];
    end

    // Lane gi always encodes digit cnt*PP_PER_CYC + gi of the latched multiplier.
    for (genvar gi = 0; gi < PP_PER_CYC; gi++) begin : g_enc
        localparam logic [SLOT_W-1:0] SLOT = SLOT_W'(gi);
        booth_digit_enc u_enc (
            .triplet_i (trip_all[{cnt_q, SLOT}]),
            .op_a_i    (op_a_q),
            .partial_o (enc_pp[gi]),
            .ovf_o     (enc_ovf[gi])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        oper_d   = oper_q;
        pp_ovf_d = pp_ovf_q;
        bank_d   = bank_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_a_d   = bus.op_a;
                    op_b_d   = bus.op_b;
                    oper_d   = bus.operation_i;
                    pp_ovf_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ENC;
                end
            end
            ENC: begin
                if (bus.flush) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    for (int j = 0; j < PP_PER_CYC; j++) begin
                        bank_d[{cnt_q, SLOT_W'(j)}] = enc_pp[SLOT_W'(j)];
                    end
                    pp_ovf_d = pp_ovf_q | (|enc_ovf);
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NUM_GRP - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            oper_q   <= 1'b0;
            pp_ovf_q <= 1'b0;
            bank_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            oper_q   <= oper_d;
            pp_ovf_q <= pp_ovf_d;
            bank_q   <= bank_d;
        end
    end

    // Status outputs are pure decodes of registered state.
    assign bus.enable_mult = (state_q == DONE);
    assign bus.mult_finish = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.operation   = oper_q;
    assign bus.pp_ovf      = pp_ovf_q;

    assign bus.partial1_booth  = bank_q[0];
    assign bus.partial2_booth  = bank_q[1];
    assign bus.partial3_booth  = bank_q[2];
    assign bus.partial4_booth  = bank_q[3];
    assign bus.partial5_booth  = bank_q[4];
    assign bus.partial6_booth  = bank_q[5];
    assign bus.partial7_booth  = bank_q[6];
    assign bus.partial8_booth  = bank_q[7];
    assign bus.partial9_booth  = bank_q[8];
    assign bus.partial10_booth = bank_q[9];
    assign bus.partial11_booth = bank_q[10];
    assign bus.partial12_booth = bank_q[11];
    assign bus.partial13_booth = bank_q[12];
    assign bus.partial14_booth = bank_q[13];
    assign bus.partial15_booth = bank_q[14];
    assign bus.partial16_booth = bank_q[15];

endmodule

// File: tb/tb_mult_booth_encoder.sv
// Bench for mult_booth_encoder: directed corner cases plus random operands,
// checked against an arithmetic Booth/product model.
module tb_mult_booth_encoder;
    import mult_booth_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_booth_encoder_if bus ();

    mult_booth_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [32:0] pp [16];
    assign pp[0]  = bus.partial1_booth;
    assign pp[1]  = bus.partial2_booth;
    assign pp[2]  = bus.partial3_booth;
    assign pp[3]  = bus.partial4_booth;
    assign pp[4]  = bus.partial5_booth;
    assign pp[5]  = bus.partial6_booth;
    assign pp[6]  = bus.partial7_booth;
    assign pp[7]  = bus.partial8_booth;
    assign pp[8]  = bus.partial9_booth;
    assign pp[9]  = bus.partial10_booth;
    assign pp[10] = bus.partial11_booth;
    assign pp[11] = bus.partial12_booth;
    assign pp[12] = bus.partial13_booth;
    assign pp[13] = bus.partial14_booth;
    assign pp[14] = bus.partial15_booth;
    assign pp[15] = bus.partial16_booth;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Booth digit as a weighted sum: -2*b[2i+1] + b[2i] + b[2i-1].
    function automatic int booth_digit(input logic [31:0] b, input int i);
        logic [32:0] be;
        be = {b, 1'b0};
        return -2 * int'(be[2*i+2]) + int'(be[2*i+1]) + int'(be[2*i]);
    endfunction

    function automatic longint pp_value(input logic [31:0] a, input logic [31:0] b, input int i);
        return longint'(booth_digit(b, i)) * longint'(signed'(a));
    endfunction

    function automatic logic exp_ovf(input logic [31:0] a, input logic [31:0] b);
        longint v;
        logic   o;
        o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = pp_value(a, b, i);
            if (v > (longint'(1) <<< 32) - 1 || v < -(longint'(1) <<< 32)) o = 1'b1;
        end
        return o;
    endfunction

    task automatic check_result(input logic [31:0] a, input logic [31:0] b, input logic op);
        longint      v;
        logic [63:0] vbits;
        longint      sum;
        logic [63:0] prod;
        logic [63:0] sumbits;
        logic        ovf;
        check("operation", bus.operation, op);
        ovf = exp_ovf(a, b);
        check("pp_ovf", bus.pp_ovf, ovf);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            v     = pp_value(a, b, i);
            vbits = v;
            check($sformatf("partial%0d", i + 1), pp[i], {31'd0, vbits[32:0]});
            sum = sum + (longint'(signed'(pp[i])) <<< (2 * i));
        end
        if (!ovf) begin
            prod    = longint'(signed'(a)) * longint'(signed'(b));
            sumbits = sum;
            if (op) check("adder_high_word", sumbits[63:32], prod[63:32]);
            else    check("adder_low_word",  sumbits[31:0],  prod[31:0]);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op, input bit dup);
        $display("op a=%h b=%h operation=%0d restart_in_enc=%0d", a, b, op, dup);
        bus.op_a        = a;
        bus.op_b        = b;
        bus.operation_i = op;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        check("busy_after_accept", bus.busy, 1'b1);
        check("pp_ovf_cleared", bus.pp_ovf, 1'b0);
        check("enable_at_accept", bus.enable_mult, 1'b0);
        bus.op_a        = $urandom;
        bus.op_b        = $urandom;
        bus.operation_i = ~op;
        for (int k = 1; k <= 4; k++) begin
            if (k == 2 && dup) bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            check($sformatf("enable_mult_E%0d", k), bus.enable_mult, (k == 4));
            check($sformatf("mult_finish_E%0d", k), bus.mult_finish, (k == 4));
            check($sformatf("busy_E%0d", k), bus.busy, 1'b1);
        end
        check_result(a, b, op);
        step();
        check("enable_after_done", bus.enable_mult, 1'b0);
        check("busy_after_done", bus.busy, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.flush       = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.operation_i = 1'b0;
        step();
        step();
        check("reset_enable", bus.enable_mult, 1'b0);
        check("reset_finish", bus.mult_finish, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_operation", bus.operation, 1'b0);
        check("reset_pp_ovf", bus.pp_ovf, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("reset_partial%0d", i + 1), pp[i], 64'd0);
        #2 rst_n = 1'b1;
        step();

        // Directed cases, including explicit partial constants.
        run_op(32'd7, 32'd3, 1'b0, 1'b0);
        check("t1_partial1_const", pp[0], 64'h1_FFFF_FFF9);
        check("t1_partial2_const", pp[1], 64'h0_0000_0007);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("t2_partial1_const", pp[0], 64'h0_0000_0001);
        run_op(32'h8000_0000, 32'd2, 1'b1, 1'b0);
        check("t3_ovf_const", bus.pp_ovf, 1'b1);
        check("t3_partial2_const", pp[1], 64'h1_8000_0000);
        run_op(32'h1234_5678, 32'h0BAD_F00D, 1'b0, 1'b0);

        // A second start during ENC is dropped; one right after DONE is taken.
        run_op(32'hCAFE_0001, 32'h7654_3210, 1'b1, 1'b1);
        run_op(32'h0000_0055, 32'hFFFF_FF00, 1'b0, 1'b0);

        // Flush mid-ENC, then a start sampled on the following edge.
        $display("op flush_in_enc");
        bus.op_a = 32'h1111_2222; bus.op_b = 32'h3333_4444; bus.operation_i = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 1'b0);
        check("flush_enable", bus.enable_mult, 1'b0);
        check("flush_finish", bus.mult_finish, 1'b0);
        run_op(32'hA5A5_5A5A, 32'h0F0F_F0F0, 1'b0, 1'b0);

        // start and flush together in IDLE: not accepted.
        $display("op start_with_flush_in_idle");
        bus.start = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("idle_flush_busy", bus.busy, 1'b0);
        step();
        check("idle_flush_enable", bus.enable_mult, 1'b0);

        // Asynchronous reset mid-ENC.
        $display("op reset_in_enc");
        bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'h1357_9BDF; bus.operation_i = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_enable", bus.enable_mult, 1'b0);
        check("arst_finish", bus.mult_finish, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_operation", bus.operation, 1'b0);
        check("arst_pp_ovf", bus.pp_ovf, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("arst_partial%0d", i + 1), pp[i], 64'd0);
        #1 rst_n = 1'b1;
        step();
        run_op(32'h0000_0009, 32'h0000_0005, 1'b0, 1'b0);

        // Random operands, biased toward the multiplicand corner values.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 4))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'h7FFF_FFFF;
                2:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            rb = $urandom;
            run_op(ra, rb, 1'($urandom_range(0, 1)), (n % 6) == 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
